// File: rtl/cache_d.sv
// cache_d: byte-write, word-organised data RAM for the CPU data channel.
// Define CACHE_D_AES_PORT_EN to add the write-only AES ciphertext port; without it the block is a plain single-port RAM.
module cache_d #(
   parameter int          ADD_WIDTH = 18,
   parameter logic [31:0] AES_BASE  = 32'h0000_004C,
   parameter int          AES_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] add,
   output logic [31:0] rdata,
   input  logic [3:0]  wen,
   input  logic [31:0] wdata,
   input  logic        wen_aes_d,
   input  logic [31:0] cipher_addr,
   input  logic [31:0] cipher_text
);

   localparam int IDX_W = ADD_WIDTH - 2;
   localparam int DEPTH = 1 << IDX_W;

   logic [31:0]      mem [DEPTH];
   logic [IDX_W-1:0] idx;
   logic             aes_hit;
   logic [IDX_W-1:0] aes_idx;
   logic [31:0]      aes_word;

   assign idx = add[ADD_WIDTH-1:2];

   // Registered read of the pre-write contents, so same-word read/write returns the old word.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else begin
         rdata <= mem[idx];
      end
   end

`ifdef CACHE_D_AES_PORT_EN
   localparam logic [31:0] AES_END = AES_BASE + 32'(4 * AES_WORDS);

   logic [31:0] aes_a;
   logic        aes_v;

   // The sequencer address runs one cycle ahead of its ciphertext, so delay it to line them up.
   always_ff @(posedge clk) begin
      if (reset) begin
         aes_a <= '0;
         aes_v <= 1'b0;
      end else begin
         aes_a <= cipher_addr;
         aes_v <= wen_aes_d;
      end
   end

   assign aes_hit  = aes_v && (aes_a >= AES_BASE) && (aes_a < AES_END);
   assign aes_idx  = aes_a[ADD_WIDTH-1:2];
   assign aes_word = cipher_text;

   logic unused;
   assign unused = &{1'b0, add[31:ADD_WIDTH], add[1:0]};
`else
   assign aes_hit  = 1'b0;
   assign aes_idx  = '0;
   assign aes_word = '0;

   logic unused;
   assign unused = &{1'b0, add[31:ADD_WIDTH], add[1:0], wen_aes_d, cipher_addr, cipher_text};
`endif

   // The AES write is issued last so it overrides every CPU byte lane when both target one word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         if (aes_hit) begin
            mem[aes_idx] <= aes_word;
         end
      end
   end

endmodule

// File: tb/tb_cache_d.sv
// tb_cache_d: directed self-checking bench for cache_d.
// Expected AES results follow CACHE_D_AES_PORT_EN, matching the build of the design.
module tb_cache_d;

   logic        clk;
   logic        reset;
   logic [31:0] add;
   logic [31:0] rdata;
   logic [3:0]  wen;
   logic [31:0] wdata;
   logic        wen_aes_d;
   logic [31:0] cipher_addr;
   logic [31:0] cipher_text;

   int check_count;
   int pass_count;

   cache_d dut (
      .clk         (clk),
      .reset       (reset),
      .add         (add),
      .rdata       (rdata),
      .wen         (wen),
      .wdata       (wdata),
      .wen_aes_d   (wen_aes_d),
      .cipher_addr (cipher_addr),
      .cipher_text (cipher_text)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      add   = a;
      wdata = d;
      wen   = w;
      @(posedge clk);
      #1;
      wen = 4'h0;
   endtask

   task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
      add = a;
      wen = 4'h0;
      @(posedge clk);
      #1;
      d = rdata;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_count++;
      if (rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
      else pass_count++;
      reset = 1'b0;
      cpu_write(32'h100, 32'hDEAD_BEEF, 4'hF);
      cpu_read(32'h100, d);
      check_count++;
      if (d !== 32'hDEAD_BEEF) $display("[TB] FAIL write_read_100: got %h expected %h", d, 32'hDEAD_BEEF);
      else pass_count++;
      cpu_write(32'h200, 32'h1357_9BDF, 4'hF);
      reset = 1'b1;
      add   = 32'h200;
      wdata = 32'h2468_ACE0;
      wen   = 4'hF;
      @(posedge clk);
      #1;
      check_count++;
      if (rdata !== 32'h0) $display("[TB] FAIL reset_hold_rdata: got %h expected %h", rdata, 32'h0);
      else pass_count++;
      wen   = 4'h0;
      reset = 1'b0;
      cpu_read(32'h200, d);
      check_count++;
      if (d !== 32'h1357_9BDF) $display("[TB] FAIL write_blocked_in_reset: got %h expected %h", d, 32'h1357_9BDF);
      else pass_count++;
   endtask

   task automatic test_byte_lanes;
      logic [31:0] d;
      cpu_write(32'h104, 32'h1122_3344, 4'hF);
      cpu_write(32'h104, 32'hAABB_CCDD, 4'b0101);
      cpu_read(32'h104, d);
      check_count++;
      if (d !== 32'h11BB_33DD) $display("[TB] FAIL byte_lanes: got %h expected %h", d, 32'h11BB_33DD);
      else pass_count++;
   endtask

   task automatic test_read_first;
      logic [31:0] d;
      cpu_write(32'h108, 32'h0, 4'hF);
      cpu_write(32'h108, 32'h55, 4'hF);
      check_count++;
      if (rdata !== 32'h0) $display("[TB] FAIL read_first_old: got %h expected %h", rdata, 32'h0);
      else pass_count++;
      cpu_read(32'h108, d);
      check_count++;
      if (d !== 32'h55) $display("[TB] FAIL read_first_new: got %h expected %h", d, 32'h55);
      else pass_count++;
   endtask

   task automatic test_address_wrap;
      logic [31:0] d;
      cpu_write(32'h0004_0110, 32'h0BAD_F00D, 4'hF);
      cpu_read(32'h110, d);
      check_count++;
      if (d !== 32'h0BAD_F00D) $display("[TB] FAIL wrap_alias: got %h expected %h", d, 32'h0BAD_F00D);
      else pass_count++;
      cpu_read(32'hFFFC_0113, d);
      check_count++;
      if (d !== 32'h0BAD_F00D) $display("[TB] FAIL upper_low_bits_ignored: got %h expected %h", d, 32'h0BAD_F00D);
      else pass_count++;
   endtask

   task automatic test_aes_burst;
      logic [31:0] seq  [0:6];
      logic [31:0] text [0:6];
      logic [31:0] chk  [0:6];
      logic [31:0] exp_v[0:6];
      logic [31:0] d;
      seq[0] = 32'h4C; seq[1] = 32'h50; seq[2] = 32'h54; seq[3] = 32'h58;
      seq[4] = 32'h5C; seq[5] = 32'h00; seq[6] = 32'h00;
      text[0] = 32'h0;           text[1] = 32'h0011_2233; text[2] = 32'h4455_6677;
      text[3] = 32'h8899_AABB;   text[4] = 32'hCCDD_EEFF; text[5] = 32'hBAD0_BAD0;
      text[6] = 32'hBAD1_BAD1;
      chk[0] = 32'h48; chk[1] = 32'h4C; chk[2] = 32'h50; chk[3] = 32'h54;
      chk[4] = 32'h58; chk[5] = 32'h5C; chk[6] = 32'h00;
      for (int i = 0; i < 7; i++) begin
         cpu_write(chk[i], 32'hA000_0000 | chk[i], 4'hF);
         exp_v[i] = 32'hA000_0000 | chk[i];
      end
`ifdef CACHE_D_AES_PORT_EN
      exp_v[1] = 32'h0011_2233;
      exp_v[2] = 32'h4455_6677;
      exp_v[3] = 32'h8899_AABB;
      exp_v[4] = 32'hCCDD_EEFF;
`endif
      for (int i = 0; i < 7; i++) begin
         wen_aes_d   = (i <= 5);
         cipher_addr = seq[i];
         cipher_text = text[i];
         @(posedge clk);
         #1;
      end
      wen_aes_d   = 1'b0;
      cipher_addr = 32'h0;
      cipher_text = 32'h0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 7; i++) begin
         cpu_read(chk[i], d);
         check_count++;
         if (d !== exp_v[i]) $display("[TB] FAIL aes_burst_%h: got %h expected %h", chk[i], d, exp_v[i]);
         else pass_count++;
      end
   endtask

   task automatic test_collision;
      logic [31:0] d;
      logic [31:0] exp50;
      logic [31:0] exp54;
`ifdef CACHE_D_AES_PORT_EN
      exp50 = 32'hCAFE_F00D;
      exp54 = 32'h0BAD_CAFE;
`else
      exp50 = 32'h1234_5678;
      exp54 = 32'hA000_0054;
`endif
      wen_aes_d   = 1'b1;
      cipher_addr = 32'h50;
      @(posedge clk);
      #1;
      wen_aes_d   = 1'b0;
      cipher_addr = 32'h0;
      cipher_text = 32'hCAFE_F00D;
      cpu_write(32'h50, 32'h1234_5678, 4'hF);
      wen_aes_d   = 1'b1;
      cipher_addr = 32'h54;
      @(posedge clk);
      #1;
      wen_aes_d   = 1'b0;
      cipher_addr = 32'h0;
      cipher_text = 32'h0BAD_CAFE;
      cpu_write(32'h104, 32'h7777_7777, 4'hF);
      cipher_text = 32'h0;
      cpu_read(32'h50, d);
      check_count++;
      if (d !== exp50) $display("[TB] FAIL collision_same_word: got %h expected %h", d, exp50);
      else pass_count++;
      cpu_read(32'h54, d);
      check_count++;
      if (d !== exp54) $display("[TB] FAIL collision_aes_other_word: got %h expected %h", d, exp54);
      else pass_count++;
      cpu_read(32'h104, d);
      check_count++;
      if (d !== 32'h7777_7777) $display("[TB] FAIL collision_cpu_other_word: got %h expected %h", d, 32'h7777_7777);
      else pass_count++;
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      reset       = 1'b1;
      add         = 32'h0;
      wen         = 4'h0;
      wdata       = 32'h0;
      wen_aes_d   = 1'b0;
      cipher_addr = 32'h0;
      cipher_text = 32'h0;
      test_reset();
      test_byte_lanes();
      test_read_first();
      test_address_wrap();
      test_aes_burst();
      test_collision();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/cache_d.md
# cache_d

Byte-addressed, word-organised data memory for the RISC-V core's data channel (channel 2), with a second write-only port through which the AES engine deposits its 128-bit ciphertext as four 32-bit words. It sits between the CPU data port and the rest of the system. Peripheral addresses, such as the UART at 0x1F0, are filtered upstream, so every write arriving here targets memory.

## Interface
- ADD_WIDTH, 18: byte-address width. The array holds 2^(ADD_WIDTH-2) 32-bit words.
- AES_BASE, 32'h0000004C: byte address of the first ciphertext word.
- AES_WORDS, 4: number of ciphertext words accepted.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- add  in  32  CPU byte address. Bits [1:0] and bits above ADD_WIDTH-1 are ignored.
- rdata  out  32  read data, registered.
- wen  in  4  CPU byte-lane write enables; wen[i] writes byte i (bits 8i+7..8i).
- wdata  in  32  CPU write data.
- wen_aes_d  in  1  AES write-window enable.
- cipher_addr  in  32  AES byte-address sequencer value.
- cipher_text  in  32  AES ciphertext word. It lags cipher_addr by one cycle.

## Operation
- Memory: word index = add[ADD_WIDTH-1:2]. Contents are not cleared by reset.
- CPU write: every edge with reset=0 writes each byte lane whose wen[i]=1. Lanes with wen[i]=0 are unchanged.
- CPU read: every edge, rdata <= word at the current index. Read-first: a read and write to the same word in one cycle returns the old value.
- AES alignment:
  - Internal registers aes_a <= cipher_addr and aes_v <= wen_aes_d on every edge. Both clear to 0 on reset.
  - On an edge where aes_v=1 and AES_BASE <= aes_a < AES_BASE+4*AES_WORDS, the full word at aes_a[ADD_WIDTH-1:2] is written with the current cipher_text.
  - Effect: the word sequence 0x4C/C[127:96], 0x50/C[95:64], 0x54/C[63:32], 0x58/C[31:0] lands correctly.
  - aes_a = 0x5C and 0x00 are outside the window, so the trailing sequencer states cause no write.
- Collision: if a CPU write and an AES write hit the same word on the same edge, AES wins on all bytes. On different words, both writes occur.
- During reset: no CPU or AES writes take effect, and rdata is held at 0.

## Timing
- Read latency: 1 cycle, from add sampled at edge N to rdata valid after edge N.
- Write latency: data is visible to a read issued on the cycle after the write edge.
- AES: cipher_text sampled on edge N is written to the address presented on edge N-1.
- Reset values: rdata=0, aes_a=0, aes_v=0.
- Full address wrap: add = 2^ADD_WIDTH + k aliases add = k.

## Configuration
- CACHE_D_AES_PORT_EN
  - Defined: AES write port, aes_a/aes_v registers and the collision rule are present as described.
  - Undefined: wen_aes_d, cipher_addr and cipher_text are ignored, no AES registers exist, and the block is a plain single-port byte-write RAM.

## Test plan
- Reset then read: assert reset for 3 cycles -> rdata=0. Release, write 0xDEADBEEF at 0x100 with wen=4'hF, read 0x100 -> rdata=0xDEADBEEF one cycle after the address is presented.
- Byte lanes: word 0x104 = 0x11223344, then write wdata=0xAABBCCDD with wen=4'b0101 -> read 0x104 = 0x11BB33DD.
- Read-first: write 0x55 to 0x108 while reading 0x108 (old 0x0) -> rdata=0x0 that cycle and 0x55 on the next read.
- AES burst: wen_aes_d=1 and sequencer 0x4C→0x50→0x54→0x58→0x5C→0x00 with text lagging C3..C0 (0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF):
  - 0x4C..0x58 hold C3..C0 in order.
  - 0x5C and 0x00 are unchanged.
- Collision: AES write of 0xCAFEF00D and CPU write of 0x12345678 to 0x50 on the same edge -> 0x50=0xCAFEF00D.
- Macro off: repeat the AES burst without CACHE_D_AES_PORT_EN -> 0x4C..0x58 unchanged.
